// File: rtl/mips_pkg.sv
// Encodings shared by the execute-stage decoder and the HI/LO multiply unit.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_LO   = 2'b01;
  localparam logic [1:0] MOVE_HI   = 2'b10;

  localparam logic [2:0] ALU_MULT = 3'b111;

endpackage

// File: rtl/mult_seq_core.sv
// Unsigned shift-add multiplier datapath: one partial-product step per cycle over WIDTH steps.
module mult_seq_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  // One spare top bit so the upper-half add can never overflow.
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH:0]     add_sum;

  always_comb begin
    add_sum  = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = {1'b0, add_sum, acc_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign last_o    = (count_q == CntW'(WIDTH - 1));
  assign product_o = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/hilo_mult_unit.sv
// Signed multi-cycle multiplier with HI/LO registers, mfhi/mflo readout and pipeline stall.
module hilo_mult_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [1:0]       move,
  output logic [WIDTH-1:0] movedata,
  output logic             busy,
  output logic             stall
);

  mult_state_e        state_q, state_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product, fixed;
  logic               load, step, last;

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a = srca[WIDTH-1] ? -srca : srca;
  assign mag_b = srcb[WIDTH-1] ? -srcb : srcb;
  assign load  = (state_q == IDLE) && start;
  assign step  = (state_q == RUN);
  assign fixed = sign_q ? -product : product;

  mult_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .load_i   (load),
    .step_i   (step),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .last_o   (last),
    .product_o(product)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = fixed;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    case (move)
      MOVE_HI: movedata = hi_q;
      MOVE_LO: movedata = lo_q;
      default: movedata = '0;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy && (start || (move == MOVE_HI) || (move == MOVE_LO));

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit against a signed-product reference model.
module tb_hilo_mult_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] srca, srcb;
  logic [1:0]   move;
  logic [W-1:0] movedata;
  logic         busy, stall;

  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;
  logic [W-1:0] hi_m, lo_m;

  hilo_mult_unit #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .srca    (srca),
    .srcb    (srcb),
    .move    (move),
    .movedata(movedata),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Issue one multiply, count busy cycles, then read LO and HI back.
  task automatic mult_and_read(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int n;
    p = ref_mul(a, b);
    @(negedge clk);
    start = 1'b1; srca = a; srcb = b; move = 2'b00;
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    hi_m = p[2*W-1:W];
    lo_m = p[W-1:0];
    n_total++;
    if (n !== 33) $display("FAIL busy_len: got %0d want 33", n); else n_pass++;
    move = 2'b01; #1;
    n_total++;
    if (movedata !== lo_m) $display("FAIL mflo %h*%h: got %h want %h", a, b, movedata, lo_m);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", stall); else n_pass++;
    move = 2'b10; #1;
    n_total++;
    if (movedata !== hi_m) $display("FAIL mfhi %h*%h: got %h want %h", a, b, movedata, hi_m);
    else n_pass++;
    move = 2'b00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; move = 2'b10; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL reset_busy_stall: got %b%b want 00", busy, stall);
    else n_pass++;
    n_total++;
    if (movedata !== '0) $display("FAIL reset_hi: got %h want 0", movedata); else n_pass++;
    start = 1'b0; move = 2'b01; #1;
    n_total++;
    if (movedata !== '0) $display("FAIL reset_lo: got %h want 0", movedata); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1; move = 2'b00;
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    ta = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000};
    tb = '{32'h0000_0005, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) mult_and_read(ta[i], tb[i]);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 2) a = 32'h8000_0000;
      if (i == 5) b = 32'h0000_0000;
      mult_and_read(a, b);
    end
  endtask

  // HI/LO must hold across idle cycles while operands wiggle.
  task automatic test_hold();
    repeat (20) begin
      @(negedge clk);
      srca = $urandom; srcb = $urandom;
    end
    move = 2'b10; #1;
    n_total++;
    if (movedata !== hi_m) $display("FAIL hold_hi: got %h want %h", movedata, hi_m); else n_pass++;
    move = 2'b01; #1;
    n_total++;
    if (movedata !== lo_m) $display("FAIL hold_lo: got %h want %h", movedata, lo_m); else n_pass++;
    move = 2'b00;
  endtask

  // mfhi presented from the second busy cycle onward, so it is held for 32 cycles.
  task automatic test_mfhi_stall();
    logic [2*W-1:0] p;
    logic [W-1:0] a, b;
    int n;
    a = $urandom; b = $urandom;
    p = ref_mul(a, b);
    @(negedge clk);
    start = 1'b1; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    move = 2'b10;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    hi_m = p[2*W-1:W];
    lo_m = p[W-1:0];
    n_total++;
    if (n !== 32) $display("FAIL mfhi_stall_len: got %0d want 32", n); else n_pass++;
    n_total++;
    if (movedata !== hi_m) $display("FAIL mfhi_after_stall: got %h want %h", movedata, hi_m);
    else n_pass++;
    move = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] pa, pb;
    logic [W-1:0] a1, b1, a2, b2, old_hi;
    int n_stall, bad, n;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    pa = ref_mul(a1, b1);
    pb = ref_mul(a2, b2);
    old_hi = hi_m;
    @(negedge clk);
    start = 1'b1; srca = a1; srcb = b1; move = 2'b00;
    @(negedge clk);
    srca = a2; srcb = b2; move = 2'b10;
    n_stall = 0; bad = 0;
    for (int i = 0; i < 33; i++) begin
      #1;
      if (stall === 1'b1) n_stall++;
      if (movedata !== old_hi) bad++;
      @(negedge clk);
    end
    n_total++;
    if (n_stall !== 33) $display("FAIL b2b_stall_len: got %0d want 33", n_stall); else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL b2b_hi_unchanged: got %0d bad cycles want 0", bad); else n_pass++;
    #1;
    n_total++;
    if (stall !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_accept: got stall=%b busy=%b want 00", stall, busy);
    else n_pass++;
    n_total++;
    if (movedata !== pa[2*W-1:W]) $display("FAIL b2b_first_hi: got %h want %h", movedata, pa[2*W-1:W]);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; move = 2'b00;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    hi_m = pb[2*W-1:W];
    lo_m = pb[W-1:0];
    n_total++;
    if (n !== 33) $display("FAIL b2b_second_len: got %0d want 33", n); else n_pass++;
    move = 2'b01; #1;
    n_total++;
    if (movedata !== lo_m) $display("FAIL b2b_second_lo: got %h want %h", movedata, lo_m); else n_pass++;
    move = 2'b10; #1;
    n_total++;
    if (movedata !== hi_m) $display("FAIL b2b_second_hi: got %h want %h", movedata, hi_m); else n_pass++;
    move = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    int n;
    @(negedge clk);
    start = 1'b1; srca = $urandom; srcb = $urandom;
    @(negedge clk);
    start = 1'b0; move = 2'b10;
    repeat (9) @(negedge clk);
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL midrun_pre_stall: got %b want 1", stall); else n_pass++;
    reset_n = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    n_total++;
    if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL midrun_reset: got busy=%b stall=%b want 00", busy, stall);
    else n_pass++;
    n_total++;
    if (movedata !== '0) $display("FAIL midrun_hi: got %h want 0", movedata); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++;
    if (movedata !== '0 || stall !== 1'b0) $display("FAIL post_reset_mfhi: got %h stall=%b want 0 0", movedata, stall);
    else n_pass++;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) n++;
    end
    n_total++;
    if (n !== 0) $display("FAIL post_reset_idle: got %0d busy cycles want 0", n); else n_pass++;
    move = 2'b01; #1;
    n_total++;
    if (movedata !== '0) $display("FAIL post_reset_lo: got %h want 0", movedata); else n_pass++;
    move = 2'b00;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_mfhi_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

Multi-cycle signed multiplier with the HI/LO register pair for the MIPS execute stage. It executes what the ALU/shift decoder requests: it starts on `mult` (alucontrol 3'b111) and returns HI or LO for `mfhi`/`mflo` (move 2'b10/2'b01). A sequential shift-add core takes WIDTH+1 cycles per multiply. A stall output holds the pipeline while a result is pending.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  multiply request; the execute stage drives it as alucontrol==3'b111 with a valid instruction.
- srca  in  WIDTH  multiplicand (rs), signed two's complement.
- srcb  in  WIDTH  multiplier (rt), signed two's complement.
- move  in  2  2'b10 mfhi, 2'b01 mflo, 2'b00 none; 2'b11 is treated as none.
- movedata  out  WIDTH  HI when move==2'b10, LO when move==2'b01, otherwise 0; combinational.
- busy  out  1  multiply in progress.
- stall  out  1  pipeline hold request; combinational.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1:
  - latch |srca| and |srcb| as magnitudes, and sign = srca[W-1]^srcb[W-1];
  - clear the 2*WIDTH accumulator and set count=0;
  - go to RUN.
- RUN, each cycle:
  - if multiplier LSB=1, add the multiplicand into the accumulator upper half;
  - shift the accumulator and multiplier right by 1;
  - count++;
  - after the iteration with count==WIDTH-1, go to FIX.
- FIX: negate the 2*WIDTH product if sign=1, write {HI,LO}, go to IDLE.
- Magnitude of the most-negative operand is 2^(W-1) held unsigned. The accumulator carries one extra bit, so no overflow is possible.
- busy = (state!=IDLE).
- stall = busy & (start | move==2'b10 | move==2'b01).
- start while busy is ignored. The stall holds that instruction, and it is accepted in the first IDLE cycle.
- HI/LO change only in FIX. Between multiplies they hold their value indefinitely.
- mfhi/mflo while IDLE returns the current HI/LO with no stall.
- Reset (any time, including mid-RUN):
  - state=IDLE, HI=0, LO=0, count=0, accumulator=0;
  - hence busy=0, stall=0, movedata=0;
  - the partial product is discarded.

## Timing
- Edge E0 samples start in IDLE.
- RUN occupies the cycles ending at edges E1..E32 (for WIDTH=32).
- FIX ends at edge E33, which writes HI/LO.
- busy is high for WIDTH+1 = 33 cycles, from after E0 through E33.
- The first non-stalled mfhi/mflo is in the cycle after E33 and sees the new value.
- A start in the cycle after E33 begins the next multiply. There is no dead cycle beyond the FIX cycle.
- movedata and stall have zero-cycle latency from move, start and state.

## Structure
- Shared package (mips_pkg):
  - state enum {IDLE, RUN, FIX};
  - move encodings MOVE_NONE=2'b00, MOVE_LO=2'b01, MOVE_HI=2'b10;
  - ALU_MULT=3'b111;
  - these are shared with the decoder.
- One sub-module, mult_seq_core:
  - holds the magnitude/shift-add datapath and the count;
  - ports are load and step controls plus the product out.
- The top level holds the FSM, the sign fix, the HI/LO registers, the movedata mux and the stall logic.

## Test plan
- 3×5: start 1 cycle → busy 33 cycles; then mflo=0x0000000F, mfhi=0x00000000.
- -2×3 (0xFFFFFFFE×0x00000003) → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- 0x80000000×0x80000000 → HI=0x40000000, LO=0x00000000.
- 0x80000000×0xFFFFFFFF → HI=0x00000000, LO=0x80000000.
- mfhi issued 1 cycle after start:
  - stall=1 for 32 cycles;
  - stall drops in the cycle after E33;
  - movedata equals the new HI in that cycle.
- Second start during busy:
  - stall=1 and HI/LO unchanged by it;
  - it is accepted after E33 and its result lands 34 cycles after the first result.
- reset_n low at RUN cycle 10:
  - busy=0, stall=0, HI=LO=0 immediately;
  - after release, mfhi returns 0 with no stall.
